// File: rtl/rec_pkg.sv
// rtl/rec_pkg.sv - shared recorder state encoding and track address helpers
package rec_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_LEN = 3'd1,
        REC    = 3'd2,
        WRITE  = 3'd3,
        WR_LEN = 3'd4
    } rec_state_e;

    // Region base; the header word lives at the base, samples start one word above it.
    function automatic logic [31:0] track_base(input logic [31:0] track, input logic [31:0] span);
        return track * span;
    endfunction

    function automatic logic [31:0] sample_addr(input logic [31:0] base, input logic [31:0] len);
        return base + 32'd1 + len;
    endfunction

endpackage

// File: rtl/rec_decim.sv
// rtl/rec_decim.sv - decimation counter: flags the accepted sample that should be stored
module rec_decim #(
    parameter int DECIM = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic clr_i,
    input  logic acc_i,
    output logic keep_o
);
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign keep_o = acc_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (acc_i) begin
            cnt_d = keep_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/record_core_mt.sv
// rtl/record_core_mt.sv - multi-track recorder from codec stream into SDRAM track regions
module record_core_mt
    import rec_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 32,
    parameter int N_TRACK    = 4,
    parameter int TRACK_SPAN = 2**20,
    parameter int DECIM      = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       rec_start,
    input  logic [$clog2(N_TRACK)-1:0] rec_track,
    input  logic                       rec_append,
    input  logic                       rec_pause,
    input  logic                       rec_stop,
    output logic                       rec_busy,
    output logic                       rec_done,
    output logic                       rec_full,
    output logic [ADDR_W-1:0]          rec_len,
    output logic                       sdram_read,
    output logic                       sdram_write,
    output logic [ADDR_W-1:0]          sdram_addr,
    output logic [DATA_W-1:0]          sdram_writedata,
    input  logic [DATA_W-1:0]          sdram_readdata,
    input  logic                       sdram_finished,
    output logic                       audio_ready,
    input  logic [DATA_W-1:0]          audio_data,
    input  logic                       audio_valid
);
    localparam logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(TRACK_SPAN - 1);

    rec_state_e        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d, base_q, base_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              stop_pend_q, stop_pend_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              decim_clr, decim_acc, decim_keep;

    logic [31:0]       base_new_w, samp_addr_w;
    logic [ADDR_W-1:0] rd_len;
    logic              unused_bits;

    assign base_new_w  = track_base(32'(rec_track), 32'(TRACK_SPAN));
    assign samp_addr_w = sample_addr(32'(base_q), 32'(len_q));
    assign rd_len      = sdram_readdata[ADDR_W-1:0];
    assign unused_bits = ^{base_new_w[31:ADDR_W], samp_addr_w[31:ADDR_W],
                           sdram_readdata[DATA_W-1:ADDR_W]};

    assign rec_busy = (state_q != IDLE);
    assign rec_done = done_q;
    assign rec_full = full_q;
    assign rec_len  = len_q;

    rec_decim #(.DECIM(DECIM)) u_decim (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr_i   (decim_clr),
        .acc_i   (decim_acc),
        .keep_o  (decim_keep)
    );

    always_comb begin
        state_d         = state_q;
        len_d           = len_q;
        base_d          = base_q;
        data_d          = data_q;
        stop_pend_d     = stop_pend_q;
        full_d          = full_q;
        done_d          = 1'b0;
        decim_clr       = 1'b0;
        decim_acc       = 1'b0;
        audio_ready     = 1'b0;
        sdram_read      = 1'b0;
        sdram_write     = 1'b0;
        sdram_addr      = '0;
        sdram_writedata = '0;
        unique case (state_q)
            IDLE: begin
                if (rec_start) begin
                    base_d      = base_new_w[ADDR_W-1:0];
                    full_d      = 1'b0;
                    stop_pend_d = 1'b0;
                    decim_clr   = 1'b1;
                    if (rec_append) begin
                        state_d = RD_LEN;
                    end else begin
                        len_d   = '0;
                        state_d = REC;
                    end
                end
            end
            RD_LEN: begin
                sdram_read = 1'b1;
                sdram_addr = base_q;
                if (sdram_finished) begin
                    len_d   = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
                    state_d = REC;
                end
            end
            REC: begin
                if (len_q == MAX_LEN) begin
                    full_d  = 1'b1;
                    state_d = WR_LEN;
                end else begin
                    audio_ready = !rec_pause;
                    // A sample arriving together with stop is handshaken but never stored.
                    if (rec_stop) begin
                        state_d = WR_LEN;
                    end else if (audio_valid && audio_ready) begin
                        decim_acc = 1'b1;
                        if (decim_keep) begin
                            data_d  = audio_data;
                            state_d = WRITE;
                        end
                    end
                end
            end
            WRITE: begin
                sdram_write     = 1'b1;
                sdram_addr      = samp_addr_w[ADDR_W-1:0];
                sdram_writedata = data_q;
                if (rec_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (sdram_finished) begin
                    len_d = len_q + 1'b1;
                    if (stop_pend_q || rec_stop) begin
                        state_d = WR_LEN;
                    end else if (len_q + 1'b1 == MAX_LEN) begin
                        full_d  = 1'b1;
                        state_d = WR_LEN;
                    end else begin
                        state_d = REC;
                    end
                end
            end
            WR_LEN: begin
                sdram_write     = 1'b1;
                sdram_addr      = base_q;
                sdram_writedata = DATA_W'(len_q);
                if (sdram_finished) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            base_q      <= '0;
            data_q      <= '0;
            stop_pend_q <= 1'b0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            base_q      <= base_d;
            data_q      <= data_d;
            stop_pend_q <= stop_pend_d;
            full_q      <= full_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_record_core_mt.sv
// tb/tb_record_core_mt.sv - scoreboard bench for record_core_mt with a small SDRAM model
module tb_record_core_mt;
    localparam int AW = 23, DW = 32, NT = 4, SPAN = 8, DEC = 2, MAXL = SPAN - 1;

    logic          i_clk, i_rst_n;
    logic          rec_start, rec_append, rec_pause, rec_stop;
    logic [1:0]    rec_track;
    logic          rec_busy, rec_done, rec_full;
    logic [AW-1:0] rec_len;
    logic          sdram_read, sdram_write, sdram_finished;
    logic [AW-1:0] sdram_addr;
    logic [DW-1:0] sdram_writedata, sdram_readdata;
    logic          audio_ready, audio_valid;
    logic [DW-1:0] audio_data;

    record_core_mt #(.ADDR_W(AW), .DATA_W(DW), .N_TRACK(NT), .TRACK_SPAN(SPAN), .DECIM(DEC)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .rec_start(rec_start), .rec_track(rec_track),
        .rec_append(rec_append), .rec_pause(rec_pause), .rec_stop(rec_stop),
        .rec_busy(rec_busy), .rec_done(rec_done), .rec_full(rec_full), .rec_len(rec_len),
        .sdram_read(sdram_read), .sdram_write(sdram_write), .sdram_addr(sdram_addr),
        .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
        .sdram_finished(sdram_finished), .audio_ready(audio_ready),
        .audio_data(audio_data), .audio_valid(audio_valid)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] mem[int];
    int            hdr_model[NT];
    int            n_checks = 0, n_errors = 0, exp_done = 0, done_cnt = 0;
    int            m_base, m_len, m_acc;
    bit            m_active = 0, m_full = 0;
    int            dmin = 0, dmax = 3;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_wr(input int a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = AW'(a);
        w.data = d;
        exp_q.push_back(w);
    endfunction

    function automatic void push_hdr();
        push_wr(m_base, DW'(m_len));
        hdr_model[m_base / SPAN] = m_len;
        exp_done++;
        m_active = 0;
        if (m_len == MAXL) m_full = 1;
    endfunction

    // Reference: every DEC-th accepted sample is stored until the region holds MAXL samples.
    function automatic void model_accept(input logic [DW-1:0] d);
        m_acc++;
        if (m_acc % DEC == 0) begin
            push_wr(m_base + 1 + m_len, d);
            m_len++;
            if (m_len == MAXL) push_hdr();
        end
    endfunction

    // SDRAM responder: random completion latency, one-cycle finished pulse.
    initial begin
        int            wait_left;
        bit            in_req;
        logic [AW-1:0] req_addr;
        sdram_finished = 1'b0;
        sdram_readdata = '0;
        in_req = 0;
        wait_left = 0;
        req_addr = '0;
        forever begin
            @(negedge i_clk);
            if (sdram_finished) begin
                sdram_finished = 1'b0;
                in_req = 0;
            end else if (!(sdram_read || sdram_write)) begin
                in_req = 0;
            end else begin
                if (!in_req) begin
                    in_req = 1;
                    req_addr = sdram_addr;
                    wait_left = $urandom_range(dmax, dmin);
                end else begin
                    chk(sdram_addr == req_addr, "addr_stable", sdram_addr, req_addr);
                end
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    if (sdram_write) mem[int'(sdram_addr)] = sdram_writedata;
                    else sdram_readdata = mem.exists(int'(sdram_addr)) ? mem[int'(sdram_addr)] : '0;
                    sdram_finished = 1'b1;
                end
            end
        end
    end

    // Monitor: compares every completed SDRAM write against the scoreboard.
    initial begin
        wr_t w;
        forever begin
            @(negedge i_clk);
            #1;
            chk(!(sdram_read && sdram_write), "rw_exclusive", {sdram_read, sdram_write}, 0);
            if (rec_done) done_cnt++;
            if (sdram_finished && sdram_write) begin
                if (exp_q.size() == 0) begin
                    chk(0, "unexpected_write", sdram_addr, 0);
                end else begin
                    w = exp_q.pop_front();
                    chk(sdram_addr == w.addr && sdram_writedata == w.data, "sdram_write",
                        {sdram_addr, sdram_writedata}, {w.addr, w.data});
                end
            end
        end
    end

    task automatic start_rec(input int trk, input bit app);
        rec_track = 2'(trk);
        rec_append = app;
        rec_start = 1'b1;
        m_base = trk * SPAN;
        m_acc = 0;
        m_active = 1;
        m_full = 0;
        m_len = app ? ((hdr_model[trk] > MAXL) ? MAXL : hdr_model[trk]) : 0;
        if (m_len == MAXL) push_hdr();
        @(negedge i_clk);
        rec_start = 1'b0;
        #1;
        chk(rec_busy == 1'b1, "busy_after_start", rec_busy, 1);
        chk(rec_full == 1'b0, "full_cleared", rec_full, 0);
    endtask

    task automatic put_sample(input logic [DW-1:0] d);
        int n = 0;
        audio_valid = 1'b1;
        audio_data = d;
        #1;
        while (!audio_ready && n < 300) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (!audio_ready) chk(0, "ready_timeout", n, 300);
        else model_accept(d);
        @(negedge i_clk);
        audio_valid = 1'b0;
    endtask

    task automatic stop_rec();
        int n = 0;
        #1;
        while (sdram_read && n < 100) begin
            @(negedge i_clk);
            #1;
            n++;
        end
        if (m_active) begin
            rec_stop = 1'b1;
            push_hdr();
            @(negedge i_clk);
            rec_stop = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge i_clk);
        while (rec_busy && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        if (rec_busy) chk(0, "idle_timeout", n, 500);
        @(negedge i_clk);
        #2;
        chk(exp_q.size() == 0, "sb_drained", exp_q.size(), 0);
        chk(done_cnt == exp_done, "done_count", done_cnt, exp_done);
        chk(rec_len == AW'(m_len), "rec_len", rec_len, m_len);
        chk(rec_full == m_full, "rec_full", rec_full, m_full);
    endtask

    initial begin
        for (int t = 0; t < NT; t++) hdr_model[t] = 0;
        rec_start = 0; rec_append = 0; rec_pause = 0; rec_stop = 0; rec_track = '0;
        audio_valid = 0; audio_data = '0;
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        #1;
        chk({rec_busy, rec_done, rec_full, sdram_read, sdram_write, audio_ready} == 0, "reset_ctrl",
            {rec_busy, rec_done, rec_full, sdram_read, sdram_write, audio_ready}, 0);
        chk(rec_len == 0, "reset_len", rec_len, 0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Fresh track 1, with a rec_start while busy that must be ignored
        start_rec(1, 0);
        for (int i = 0; i < 8; i++) begin
            put_sample(32'h100 + i);
            if (i == 3) begin
                rec_track = 2'd3;
                rec_start = 1'b1;
                @(negedge i_clk);
                rec_start = 1'b0;
            end
        end
        stop_rec();
        wait_idle();
        chk(mem[8] == 32'd4, "t1_header", mem[8], 4);
        chk(mem[9] == 32'h101 && mem[12] == 32'h107, "t1_samples", {mem[9], mem[12]}, {32'h101, 32'h107});

        // Append onto a preloaded header
        mem[16] = 32'd3;
        hdr_model[2] = 3;
        start_rec(2, 1);
        for (int i = 0; i < 4; i++) put_sample(32'hA0 + i);
        stop_rec();
        wait_idle();
        chk(mem[16] == 32'd5, "t2_header", mem[16], 5);
        chk(mem[20] == 32'hA1 && mem[21] == 32'hA3, "t2_samples", {mem[20], mem[21]}, {32'hA1, 32'hA3});

        // Pause with valid held high
        start_rec(0, 0);
        for (int i = 0; i < 3; i++) put_sample($urandom);
        rec_pause = 1'b1;
        audio_valid = 1'b1;
        audio_data = 32'hDEAD;
        repeat (6) @(negedge i_clk);
        for (int i = 0; i < 50; i++) begin
            #1;
            if (i % 10 == 0 || audio_ready || sdram_read || sdram_write || rec_len != AW'(m_len)) begin
                chk(!audio_ready && !sdram_read && !sdram_write, "pause_quiet",
                    {audio_ready, sdram_read, sdram_write}, 0);
                chk(rec_len == AW'(m_len), "pause_len", rec_len, m_len);
            end
            @(negedge i_clk);
        end
        rec_pause = 1'b0;
        audio_valid = 1'b0;
        for (int i = 0; i < 3; i++) put_sample($urandom);
        stop_rec();
        wait_idle();

        // Stop during a slow WRITE: the in-flight sample is committed before the header
        dmin = 5; dmax = 5;
        start_rec(2, 1);
        put_sample(32'h55);
        put_sample(32'h66);
        #1;
        chk(sdram_write == 1'b1, "t4_in_write", sdram_write, 1);
        stop_rec();
        wait_idle();
        dmin = 0; dmax = 3;
        chk(mem[16] == 32'd6 && mem[22] == 32'h66, "t4_commit", {mem[16], mem[22]}, {32'd6, 32'h66});

        // Capacity: automatic header write and sticky full
        start_rec(3, 0);
        for (int i = 0; i < 40 && m_active; i++) put_sample($urandom);
        audio_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk(audio_ready == 1'b0, "full_not_ready", audio_ready, 0);
            @(negedge i_clk);
        end
        audio_valid = 1'b0;
        wait_idle();
        chk(mem[24] == MAXL, "t5_header", mem[24], MAXL);

        // Reset mid-WRITE abandons the transfer
        dmin = 10; dmax = 10;
        start_rec(0, 0);
        put_sample(32'h77);
        put_sample(32'h88);
        repeat (2) @(negedge i_clk);
        #1;
        chk(sdram_write == 1'b1, "t6_write_pending", sdram_write, 1);
        i_rst_n = 1'b0;
        #1;
        chk({rec_busy, rec_done, rec_full, sdram_read, sdram_write, audio_ready} == 0, "rst_ctrl",
            {rec_busy, rec_done, rec_full, sdram_read, sdram_write, audio_ready}, 0);
        chk(rec_len == 0 && sdram_addr == 0 && sdram_writedata == 0, "rst_data",
            {rec_len, sdram_addr, sdram_writedata}, 0);
        exp_q.delete();
        m_active = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        dmin = 0; dmax = 3;
        repeat (12) @(negedge i_clk);
        chk(mem[0] == DW'(hdr_model[0]), "t6_header_kept", mem[0], hdr_model[0]);
        start_rec(0, 0);
        for (int i = 0; i < 4; i++) put_sample($urandom);
        stop_rec();
        wait_idle();

        // Stop while idle is ignored
        rec_stop = 1'b1;
        @(negedge i_clk);
        rec_stop = 1'b0;
        repeat (3) @(negedge i_clk);
        #1;
        chk(rec_busy == 1'b0 && done_cnt == exp_done, "idle_stop", {rec_busy, 1'b0}, 0);

        // Random sessions
        for (int s = 0; s < 8; s++) begin
            start_rec($urandom_range(0, NT - 1), 1'($urandom_range(0, 1)));
            for (int i = 0, n = $urandom_range(0, 12); i < n && m_active; i++) put_sample($urandom);
            stop_rec();
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
